action_selector: RTL and testbench

//   Epsilon-greedy action chooser for the 5x5 grid-world agent (states 1..25).

---
 rtl/action_selector_if.sv | 25 ++
 rtl/action_selector.sv | 124 ++++++++++++
 tb/tb_action_selector.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/action_selector_if.sv
// Decision-request / Q-table-read bundle between the agent controller and action_selector.
// master = the selector itself; slave = the environment (controller plus Q-table).
interface action_selector_if #(
    parameter int unsigned QW = 16
) ();
    logic          start;
    logic [5:0]    current_state;
    logic          q_rd_en;
    logic [7:0]    q_rd_addr;
    logic [QW-1:0] q_rd_data;
    logic [3:0]    next_action;
    logic          action_valid;
    logic          explored;
    logic          busy;

    modport master (
        input  start, current_state, q_rd_data,
        output q_rd_en, q_rd_addr, next_action, action_valid, explored, busy
    );

    modport slave (
        output start, current_state, q_rd_data,
        input  q_rd_en, q_rd_addr, next_action, action_valid, explored, busy
    );
endinterface

// File: rtl/action_selector.sv
// Epsilon-greedy action chooser: reads the four Q-values for the current state,
// then emits either the signed argmax or an LFSR-drawn random action.
module action_selector #(
    parameter int unsigned QW         = 16,
    parameter logic [7:0]  EPS_THRESH = 8'd26,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic              clk,
    input  logic              rst_n,
    action_selector_if.master bus
);
    typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;

    state_t               r_fsm;
    logic [15:0]          r_lfsr;
    logic [5:0]           r_state;
    logic [1:0]           r_k;
    logic                 r_explore;
    logic [1:0]           r_rand;
    logic signed [QW-1:0] r_max;
    logic [1:0]           r_arg;
    logic                 r_q_rd_en;
    logic [7:0]           r_q_rd_addr;
    logic [3:0]           r_next_action;
    logic                 r_action_valid;
    logic                 r_explored;
    logic                 r_busy;

    logic [15:0]          w_lfsr_next;
    logic                 w_state_ok;
    logic signed [QW-1:0] w_q;
    logic                 w_gt;
    logic [1:0]           w_k_inc;
    logic [1:0]           w_k_dec;
    logic [1:0]           w_final_arg;

    // Fibonacci LFSR, taps 16,14,13,11
    assign w_lfsr_next = {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
    assign w_state_ok  = (bus.current_state >= 6'd1) && (bus.current_state <= 6'd25);
    assign w_q         = $signed(bus.q_rd_data);
    assign w_gt        = w_q > r_max;
    assign w_k_inc     = r_k + 2'd1;
    assign w_k_dec     = r_k - 2'd1;
    // DRAIN folds the action-3 sample straight into the result instead of spending a cycle
    assign w_final_arg = w_gt ? 2'd3 : r_arg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fsm          <= S_IDLE;
            r_lfsr         <= LFSR_SEED;
            r_state        <= '0;
            r_k            <= '0;
            r_explore      <= 1'b0;
            r_rand         <= '0;
            r_max          <= '0;
            r_arg          <= '0;
            r_q_rd_en      <= 1'b0;
            r_q_rd_addr    <= '0;
            r_next_action  <= 4'hF;
            r_action_valid <= 1'b0;
            r_explored     <= 1'b0;
            r_busy         <= 1'b0;
        end else begin
            r_action_valid <= 1'b0;
            case (r_fsm)
                S_IDLE: begin
                    if (bus.start) begin
                        r_lfsr <= w_lfsr_next;
                        r_busy <= 1'b1;
                        if (w_state_ok) begin
                            r_state     <= bus.current_state;
                            r_explore   <= (w_lfsr_next[7:0] < EPS_THRESH);
                            r_rand      <= w_lfsr_next[9:8];
                            r_k         <= '0;
                            r_q_rd_en   <= 1'b1;
                            r_q_rd_addr <= {bus.current_state, 2'd0};
                            r_fsm       <= S_READ;
                        end else begin
                            r_next_action  <= 4'hF;
                            r_explored     <= 1'b0;
                            r_action_valid <= 1'b1;
                            r_fsm          <= S_DONE;
                        end
                    end
                end
                S_READ: begin
                    // data for read k-1 arrives while read k is being issued
                    if (r_k == 2'd1) begin
                        r_max <= w_q;
                        r_arg <= 2'd0;
                    end else if (r_k != 2'd0 && w_gt) begin
                        r_max <= w_q;
                        r_arg <= w_k_dec;
                    end
                    if (r_k == 2'd3) begin
                        r_q_rd_en <= 1'b0;
                        r_fsm     <= S_DRAIN;
                    end else begin
                        r_k         <= w_k_inc;
                        r_q_rd_addr <= {r_state, w_k_inc};
                    end
                end
                S_DRAIN: begin
                    r_next_action  <= {2'b00, (r_explore ? r_rand : w_final_arg)};
                    r_explored     <= r_explore;
                    r_action_valid <= 1'b1;
                    r_fsm          <= S_DONE;
                end
                S_DONE: begin
                    r_busy <= 1'b0;
                    r_fsm  <= S_IDLE;
                end
                default: r_fsm <= S_IDLE;
            endcase
        end
    end

    assign bus.q_rd_en      = r_q_rd_en;
    assign bus.q_rd_addr    = r_q_rd_addr;
    assign bus.next_action  = r_next_action;
    assign bus.action_valid = r_action_valid;
    assign bus.explored     = r_explored;
    assign bus.busy         = r_busy;
endmodule

// File: tb/tb_action_selector.sv
// Directed bench: a greedy instance (EPS_THRESH=0) and an always-explore instance
// (EPS_THRESH=8'hFF) share the same stimulus and a behavioural Q-table.
module tb_action_selector;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic tb_start = 1'b0;
    logic [5:0] tb_state = '0;
    logic signed [15:0] qmem [256];
    logic [15:0] ref_lfsr;
    logic [3:0] seen;
    int n_tests = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    action_selector_if #(.QW(16)) ifg ();
    action_selector_if #(.QW(16)) ifx ();

    action_selector #(.QW(16), .EPS_THRESH(8'd0), .LFSR_SEED(16'hACE1)) u_greedy (
        .clk(clk), .rst_n(rst_n), .bus(ifg.master));
    action_selector #(.QW(16), .EPS_THRESH(8'hFF), .LFSR_SEED(16'hACE1)) u_explore (
        .clk(clk), .rst_n(rst_n), .bus(ifx.master));

    assign ifg.start = tb_start;
    assign ifx.start = tb_start;
    assign ifg.current_state = tb_state;
    assign ifx.current_state = tb_state;

    // one-cycle-latency Q-table
    always @(posedge clk) begin
        if (ifg.q_rd_en) ifg.q_rd_data <= qmem[ifg.q_rd_addr];
        if (ifx.q_rd_en) ifx.q_rd_data <= qmem[ifx.q_rd_addr];
    end

    function automatic logic [15:0] lfsr_step(input logic [15:0] l);
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Valid-state decision; greedy is the hand-computed argmax for state s.
    task automatic decide(input logic [5:0] s, input logic [1:0] greedy, input bit full);
        logic exp_expl;
        logic [1:0] exp_x;
        @(negedge clk);
        tb_start = 1'b1;
        tb_state = s;
        ref_lfsr = lfsr_step(ref_lfsr);
        exp_expl = (ref_lfsr[7:0] < 8'hFF);
        exp_x    = exp_expl ? ref_lfsr[9:8] : greedy;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            tb_start = 1'b0;
            if (full) begin
                check("rd_en", 32'(ifg.q_rd_en), 32'd1);
                check("rd_addr", 32'(ifg.q_rd_addr), 32'({s, 2'(k)}));
                check("early_valid", 32'(ifg.action_valid), 32'd0);
                check("busy_read", 32'(ifg.busy), 32'd1);
            end
        end
        @(negedge clk);
        if (full) begin
            check("drain_rd_en", 32'(ifg.q_rd_en), 32'd0);
            check("drain_valid", 32'(ifg.action_valid), 32'd0);
            check("drain_addr_hold", 32'(ifg.q_rd_addr), 32'({s, 2'd3}));
        end
        @(negedge clk);
        check("g_valid", 32'(ifg.action_valid), 32'd1);
        check("g_busy", 32'(ifg.busy), 32'd1);
        check("g_action", 32'(ifg.next_action), 32'(greedy));
        check("g_explored", 32'(ifg.explored), 32'd0);
        check("x_valid", 32'(ifx.action_valid), 32'd1);
        check("x_action", 32'(ifx.next_action), 32'(exp_x));
        check("x_explored", 32'(ifx.explored), 32'(exp_expl));
        seen[ifx.next_action[1:0]] = 1'b1;
        @(negedge clk);
        if (full) begin
            check("valid_drop", 32'(ifg.action_valid), 32'd0);
            check("busy_drop", 32'(ifg.busy), 32'd0);
            check("action_hold", 32'(ifg.next_action), 32'(greedy));
        end
    endtask

    task automatic decide_invalid(input logic [5:0] s);
        @(negedge clk);
        tb_start = 1'b1;
        tb_state = s;
        ref_lfsr = lfsr_step(ref_lfsr);
        @(negedge clk);
        tb_start = 1'b0;
        check("inv_valid", 32'(ifg.action_valid), 32'd1);
        check("inv_action", 32'(ifg.next_action), 32'hF);
        check("inv_busy", 32'(ifg.busy), 32'd1);
        check("inv_rd_en", 32'(ifg.q_rd_en), 32'd0);
        check("inv_x_action", 32'(ifx.next_action), 32'hF);
        check("inv_x_explored", 32'(ifx.explored), 32'd0);
        @(negedge clk);
        check("inv_valid_drop", 32'(ifg.action_valid), 32'd0);
        check("inv_busy_drop", 32'(ifg.busy), 32'd0);
        check("inv_rd_en2", 32'(ifg.q_rd_en), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 256; i++) qmem[i] = '0;
        qmem[8'h1C] = 16'sd10;  qmem[8'h1D] = -16'sd3;
        qmem[8'h1E] = 16'sd42;  qmem[8'h1F] = 16'sd5;
        for (int i = 8'h34; i <= 8'h37; i++) qmem[i] = 16'h0100;
        qmem[8'h64] = 16'h8000; qmem[8'h65] = 16'h8000;
        qmem[8'h66] = 16'h7FFF; qmem[8'h67] = 16'h8001;
        qmem[8'h04] = -16'sd5;  qmem[8'h05] = -16'sd2;
        qmem[8'h06] = -16'sd2;  qmem[8'h07] = -16'sd9;
        ref_lfsr = 16'hACE1;
        seen = '0;

        repeat (3) @(negedge clk);
        check("rst_action", 32'(ifg.next_action), 32'hF);
        check("rst_valid", 32'(ifg.action_valid), 32'd0);
        check("rst_busy", 32'(ifg.busy), 32'd0);
        check("rst_rd_en", 32'(ifg.q_rd_en), 32'd0);
        check("rst_rd_addr", 32'(ifg.q_rd_addr), 32'd0);
        check("rst_explored", 32'(ifx.explored), 32'd0);
        rst_n = 1'b1;

        decide(6'd7, 2'd2, 1'b1);
        decide(6'd13, 2'd0, 1'b1);
        decide(6'd25, 2'd2, 1'b1);
        decide(6'd1, 2'd1, 1'b1);

        decide_invalid(6'd0);
        decide_invalid(6'd26);

        for (int n = 0; n < 200; n++) decide(6'd7, 2'd2, 1'b0);
        check("all_actions_seen", 32'(seen), 32'hF);

        // start held for 20 sampling edges: accepted at E0, E7, E14
        @(negedge clk);
        tb_start = 1'b1;
        tb_state = 6'd7;
        for (int n = 0; n < 3; n++) ref_lfsr = lfsr_step(ref_lfsr);
        for (int i = 0; i < 26; i++) begin
            @(negedge clk);
            if (i == 19) tb_start = 1'b0;
            check("held_start_valid", 32'(ifg.action_valid), 32'((i == 5) || (i == 12) || (i == 19)));
            if (i == 19) check("held_start_action", 32'(ifg.next_action), 32'd2);
        end

        // reset during T+3 aborts the decision
        @(negedge clk);
        tb_start = 1'b1;
        tb_state = 6'd13;
        @(negedge clk);
        tb_start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_rd_en", 32'(ifg.q_rd_en), 32'd0);
        check("abort_rd_addr", 32'(ifg.q_rd_addr), 32'd0);
        check("abort_busy", 32'(ifg.busy), 32'd0);
        check("abort_action", 32'(ifg.next_action), 32'hF);
        check("abort_x_action", 32'(ifx.next_action), 32'hF);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("abort_no_valid", 32'(ifg.action_valid), 32'd0);
        end
        rst_n = 1'b1;
        ref_lfsr = 16'hACE1;
        decide(6'd13, 2'd0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
